// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, stage quotas and sequencer state encoding
package game_pkg;

  localparam int NUM_STAGES = 4;
  localparam int STAGE_KILLS [NUM_STAGES] = '{8, 12, 16, 20};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_CLEARED = 2'd2,
    ST_DEAD    = 2'd3
  } stage_seq_st_t;

  function automatic int stage_kills(input int idx);
    return STAGE_KILLS[idx];
  endfunction

endpackage

// File: rtl/hit_cooldown_timer.sv
// rtl/hit_cooldown_timer.sv - post-hit invulnerability counter, decrements only while run is high
module hit_cooldown_timer #(
  parameter int COOLDOWN = 64
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic load,
  input  logic run,
  output logic busy
);

  localparam int CW = $clog2(COOLDOWN + 1);

  logic [CW-1:0] count;

  // clear beats load so a restart in the same cycle as a hit leaves no window open
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(COOLDOWN);
    end else if (run && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - stage, kill quota and lives tracker feeding the game-flow controller
module stage_sequencer
  import game_pkg::*;
#(
  parameter int NUM_STAGES   = game_pkg::NUM_STAGES,
  parameter int LIVES        = 3,
  parameter int KILL_WIDTH   = 6,
  parameter int HIT_COOLDOWN = 64
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  new_game,
  input  logic                  run,
  input  logic                  monster_hit,
  input  logic                  player_hit,
  input  logic                  stage_ack,
  output logic [2:0]            stage_num,
  output logic                  win_stage,
  output logic                  last_stage,
  output logic                  player_destroyed,
  output logic [1:0]            lives_left,
  output logic [KILL_WIDTH-1:0] kills_left
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] PLAY    = ST_PLAY;
  localparam logic [1:0] CLEARED = ST_CLEARED;
  localparam logic [1:0] DEAD    = ST_DEAD;

  logic [1:0]            state;
  logic                  cooldown_busy;
  logic                  count_en;
  logic                  kill_take;
  logic                  life_take;
  logic                  advance;
  logic [KILL_WIDTH-1:0] kills_next;
  logic [1:0]            lives_next;

  assign count_en  = run && (state == PLAY);
  assign kill_take = count_en && monster_hit;
  assign life_take = count_en && player_hit && !cooldown_busy;
  assign advance   = (state == CLEARED) && stage_ack && !last_stage;

  assign kills_next = (kill_take && kills_left != '0) ? kills_left - KILL_WIDTH'(1) : kills_left;
  assign lives_next = (life_take && lives_left != 2'd0) ? lives_left - 2'd1 : lives_left;

  hit_cooldown_timer #(
    .COOLDOWN (HIT_COOLDOWN)
  ) u_cooldown (
    .clk    (clk),
    .resetN (resetN),
    .clear  (new_game || advance),
    .load   (life_take),
    .run    (run),
    .busy   (cooldown_busy)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      stage_num  <= 3'd0;
      lives_left <= 2'd0;
      kills_left <= '0;
    end else if (new_game) begin
      state      <= PLAY;
      stage_num  <= 3'd0;
      lives_left <= 2'(LIVES);
      kills_left <= KILL_WIDTH'(stage_kills(0));
    end else begin
      case (state)
        PLAY: begin
          kills_left <= kills_next;
          lives_left <= lives_next;
          // a fatal hit outranks clearing the stage in the same cycle
          if (lives_next == 2'd0) begin
            state <= DEAD;
          end else if (kills_next == '0) begin
            state <= CLEARED;
          end
        end
        CLEARED: begin
          if (advance) begin
            state      <= PLAY;
            stage_num  <= stage_num + 3'd1;
            kills_left <= KILL_WIDTH'(stage_kills(int'(stage_num) + 1));
          end
        end
        default: ;
      endcase
    end
  end

  assign win_stage        = (state == CLEARED);
  assign player_destroyed = (state == DEAD);
  assign last_stage       = (stage_num == 3'(NUM_STAGES - 1));

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer with directed hand-computed vectors
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       resetN, new_game, run, monster_hit, player_hit, stage_ack;
  logic [2:0] stage_num;
  logic       win_stage, last_stage, player_destroyed;
  logic [1:0] lives_left;
  logic [5:0] kills_left;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES   (4),
    .LIVES        (3),
    .KILL_WIDTH   (6),
    .HIT_COOLDOWN (4)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .new_game         (new_game),
    .run              (run),
    .monster_hit      (monster_hit),
    .player_hit       (player_hit),
    .stage_ack        (stage_ack),
    .stage_num        (stage_num),
    .win_stage        (win_stage),
    .last_stage       (last_stage),
    .player_destroyed (player_destroyed),
    .lives_left       (lives_left),
    .kills_left       (kills_left)
  );

  typedef struct {
    int         at;
    string      nm;
    logic [2:0] st;
    logic       win;
    logic       last;
    logic       dead;
    logic [1:0] lives;
    logic [5:0] kills;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic [2:0] ex_st;
  logic       ex_win, ex_last, ex_dead;
  logic [1:0] ex_lives;
  logic [5:0] ex_kills;

  // monitor: one sample per edge, compares every expectation due at this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        total++;
        if (e.at != cyc || stage_num !== e.st || win_stage !== e.win || last_stage !== e.last ||
            player_destroyed !== e.dead || lives_left !== e.lives || kills_left !== e.kills) begin
          bad++;
          $display("FAIL %s @%0d: got st=%0d win=%0b last=%0b dead=%0b lives=%0d kills=%0d, want st=%0d win=%0b last=%0b dead=%0b lives=%0d kills=%0d",
                   e.nm, cyc, stage_num, win_stage, last_stage, player_destroyed, lives_left, kills_left,
                   e.st, e.win, e.last, e.dead, e.lives, e.kills);
        end
      end
    end
  end

  task automatic expect_out(input logic [2:0] st, input logic win, input logic last,
                            input logic dead, input logic [1:0] lives, input int kills);
    ex_st    = st;
    ex_win   = win;
    ex_last  = last;
    ex_dead  = dead;
    ex_lives = lives;
    ex_kills = 6'(kills);
  endtask

  task automatic tick(input string nm, input logic ng, input logic mh, input logic ph, input logic ack);
    exp_t e;
    new_game    = ng;
    monster_hit = mh;
    player_hit  = ph;
    stage_ack   = ack;
    e.at    = cyc + 1;
    e.nm    = nm;
    e.st    = ex_st;
    e.win   = ex_win;
    e.last  = ex_last;
    e.dead  = ex_dead;
    e.lives = ex_lives;
    e.kills = ex_kills;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    new_game    = 1'b0;
    monster_hit = 1'b0;
    player_hit  = 1'b0;
    stage_ack   = 1'b0;
  endtask

  task automatic clear_stage(input logic [2:0] st, input int quota, input logic last);
    for (int i = 1; i <= quota; i++) begin
      expect_out(st, i == quota, last, 1'b0, 2'd3, quota - i);
      tick("clear_kill", 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    resetN = 1'b0; new_game = 1'b0; run = 1'b0;
    monster_hit = 1'b0; player_hit = 1'b0; stage_ack = 1'b0;
    @(negedge clk);

    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    tick("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;

    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd3, 8);
    tick("new_game", 1'b1, 1'b0, 1'b0, 1'b0);

    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_out(3'd0, i == 7, 1'b0, 1'b0, 2'd3, 7 - i);
      tick("s0_kill", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    expect_out(3'd1, 1'b0, 1'b0, 1'b0, 2'd3, 12);
    tick("ack_first", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("ack_held1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("ack_held2", 1'b0, 1'b0, 1'b0, 1'b1);

    run = 1'b0;
    tick("run0_mhit", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("run0_phit", 1'b0, 1'b0, 1'b1, 1'b0);
    run = 1'b1;

    expect_out(3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 12);
    tick("cd_hit0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick("cd_idle1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("cd_hit2_ignored", 1'b0, 1'b0, 1'b1, 1'b0);
    tick("cd_idle3", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("cd_idle4", 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(3'd1, 1'b0, 1'b0, 1'b0, 2'd1, 12);
    tick("cd_hit5", 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      expect_out(3'd1, 1'b0, 1'b0, 1'b0, 2'd1, 11 - i);
      tick("s1_kill", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    expect_out(3'd1, 1'b0, 1'b0, 1'b1, 2'd0, 0);
    tick("dead_over_win", 1'b0, 1'b1, 1'b1, 1'b0);
    tick("dead_hold", 1'b0, 1'b1, 1'b1, 1'b1);

    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd3, 8);
    tick("restart_from_dead", 1'b1, 1'b0, 1'b0, 1'b0);

    clear_stage(3'd0, 8, 1'b0);
    expect_out(3'd1, 1'b0, 1'b0, 1'b0, 2'd3, 12);
    tick("ack_s1", 1'b0, 1'b0, 1'b0, 1'b1);
    clear_stage(3'd1, 12, 1'b0);
    expect_out(3'd2, 1'b0, 1'b0, 1'b0, 2'd3, 16);
    tick("ack_s2", 1'b0, 1'b0, 1'b0, 1'b1);
    clear_stage(3'd2, 16, 1'b0);
    expect_out(3'd3, 1'b0, 1'b1, 1'b0, 2'd3, 20);
    tick("ack_s3", 1'b0, 1'b0, 1'b0, 1'b1);
    clear_stage(3'd3, 20, 1'b1);

    expect_out(3'd3, 1'b1, 1'b1, 1'b0, 2'd3, 0);
    tick("ack_on_last", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("ack_on_last2", 1'b0, 1'b1, 1'b0, 1'b1);

    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd3, 8);
    tick("restart_from_last", 1'b1, 1'b0, 1'b0, 1'b1);

    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 7);
    tick("mid_play_both", 1'b0, 1'b1, 1'b1, 1'b0);

    resetN = 1'b0;
    expect_out(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    tick("mid_play_reset", 1'b0, 1'b1, 1'b0, 1'b0);
    resetN = 1'b1;
    tick("idle_ignores_hits", 1'b0, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
